// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch sequencer.
// Imported by the sequencer, its output buffer and the bench.
package fetch_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam int unsigned PC_STEP = 4;

  // canonical addi x0,x0,0 for bubble insertion downstream
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_out_buffer.sv
// fetch_out_buffer: registered output slot plus one skid entry
// between the fetch FSM and decode.
module fetch_out_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [31:0]           i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [31:0]           o_data,
  output logic                  o_full
);

  logic                  r_out_v;
  logic [ADDR_WIDTH-1:0] r_out_pc;
  logic [31:0]           r_out_d;
  logic                  r_skid_v;
  logic [ADDR_WIDTH-1:0] r_skid_pc;
  logic [31:0]           r_skid_d;
  logic                  w_out_free;

  assign w_out_free = ~r_out_v | i_pop;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out_v   <= 1'b0;
      r_out_pc  <= '0;
      r_out_d   <= '0;
      r_skid_v  <= 1'b0;
      r_skid_pc <= '0;
      r_skid_d  <= '0;
    end else if (i_flush) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_out_free) begin
      // skid is older than any new push, so it drains first
      if (r_skid_v) begin
        r_out_v  <= 1'b1;
        r_out_pc <= r_skid_pc;
        r_out_d  <= r_skid_d;
        r_skid_v <= 1'b0;
      end else if (i_push) begin
        r_out_v  <= 1'b1;
        r_out_pc <= i_pc;
        r_out_d  <= i_data;
      end else begin
        r_out_v <= 1'b0;
      end
    end else if (i_push) begin
      r_skid_v  <= 1'b1;
      r_skid_pc <= i_pc;
      r_skid_d  <= i_data;
    end
  end

  assign o_valid = r_out_v;
  assign o_pc    = r_out_pc;
  assign o_data  = r_out_d;
  assign o_full  = r_skid_v;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and single-outstanding imem fetch FSM,
// with redirect kill/flush and a valid/ready port to decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_fetch_enable,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_imem_req,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [31:0]           i_imem_rdata,
  output logic                  o_if_valid,
  input  logic                  i_if_ready,
  output logic [ADDR_WIDTH-1:0] o_if_pc,
  output logic [31:0]           o_if_instruction
);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_kill;

  logic [ADDR_WIDTH-1:0] w_target;
  logic [1:0]            w_resume;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;

  assign w_target = i_redirect_pc & ~ADDR_WIDTH'(3);
  assign w_resume = i_fetch_enable ? S_REQ : S_IDLE;

  // a redirect squashes the decode handshake of the same cycle
  assign w_pop  = o_if_valid & i_if_ready & ~i_redirect_valid;
  assign w_push = (r_state == S_WAIT) & i_imem_rvalid
                & ~r_kill & ~i_redirect_valid;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_kill   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_fetch_enable)
            r_state <= S_REQ;
        end
        S_REQ: begin
          if (i_imem_gnt) begin
            r_req_pc <= r_pc;
            r_kill   <= i_redirect_valid;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            r_kill <= 1'b0;
            if (w_push & o_if_valid & ~w_pop)
              r_state <= S_HOLD;
            else
              r_state <= w_resume;
          end else if (i_redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_redirect_valid | w_pop | ~w_full)
            r_state <= w_resume;
        end
        default: r_state <= S_IDLE;
      endcase

      if (i_redirect_valid)
        r_pc <= w_target;
      else if ((r_state == S_REQ) & i_imem_gnt)
        r_pc <= r_pc + ADDR_WIDTH'(PC_STEP);
    end
  end

  assign o_imem_req  = (r_state == S_REQ);
  assign o_imem_addr = r_pc;

  fetch_out_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_out_buf (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_push   (w_push),
    .i_pc     (r_req_pc),
    .i_data   (i_imem_rdata),
    .i_pop    (w_pop),
    .i_flush  (i_redirect_valid),
    .o_valid  (o_if_valid),
    .o_pc     (o_if_pc),
    .o_data   (o_if_instruction),
    .o_full   (w_full)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of sequencing, backpressure,
// redirect flushing, PC wrap and mid-transaction reset.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fe;
  logic        redir;
  logic [31:0] redir_pc;
  logic        ready;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        vld;
  logic [31:0] pc;
  logic [31:0] instr;

  logic        rv_en;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  logic        req2;
  logic        vld2;
  logic        pend2 = 1'b0;
  logic [31:0] addr2;
  logic [31:0] pc2;
  logic [31:0] instr2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  fetch_sequencer u_dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_fetch_enable  (fe),
    .i_redirect_valid(redir),
    .i_redirect_pc   (redir_pc),
    .o_imem_req      (req),
    .o_imem_addr     (addr),
    .i_imem_gnt      (gnt),
    .i_imem_rvalid   (rvalid),
    .i_imem_rdata    (rdata),
    .o_if_valid      (vld),
    .i_if_ready      (ready),
    .o_if_pc         (pc),
    .o_if_instruction(instr)
  );

  fetch_sequencer #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_fetch_enable  (fe),
    .i_redirect_valid(1'b0),
    .i_redirect_pc   (32'h0),
    .o_imem_req      (req2),
    .o_imem_addr     (addr2),
    .i_imem_gnt      (req2),
    .i_imem_rvalid   (pend2),
    .i_imem_rdata    (NOP),
    .o_if_valid      (vld2),
    .i_if_ready      (1'b1),
    .o_if_pc         (pc2),
    .o_if_instruction(instr2)
  );

  // memory: grants at once, answers one cycle after grant
  always @(posedge clk) begin
    if (req && gnt) begin
      mem_pend <= 1'b1;
      mem_addr <= addr;
    end else if (rvalid) begin
      mem_pend <= 1'b0;
    end
    pend2 <= req2;
  end

  always @(negedge clk) begin
    gnt    = req;
    rvalid = mem_pend & rv_en;
    rdata  = rvalid ? word(mem_addr) : 32'h0;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    rv_en = 1'b1;
    redir = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    fe       = 1'b1;
    redir    = 1'b0;
    redir_pc = 32'h0;
    ready    = 1'b1;
    rv_en    = 1'b1;
    step(2);
    check("rst_req",   32'(req), 32'd0);
    check("rst_addr",  addr,     32'h0);
    check("rst_valid", 32'(vld), 32'd0);
    check("rst_pc",    pc,       32'h0);
    check("rst_instr", instr,    32'h0);
    check("rst_addr2", addr2,    32'hFFFF_FFFC);

    // streaming at one instruction per two cycles, plus PC wrap
    rst_n = 1'b1;
    step();
    check("t1_req0",  32'(req), 32'd1);
    check("t1_addr0", addr,     32'h0);
    check("t5_addr0", addr2,    32'hFFFF_FFFC);
    step();
    check("t1_wait",  32'(req), 32'd0);
    check("t5_wrap",  addr2,    32'h0);
    step();
    check("t1_v0",    32'(vld), 32'd1);
    check("t1_pc0",   pc,       32'h0);
    check("t1_ins0",  instr,    word(32'h0));
    check("t1_addr4", addr,     32'h4);
    check("t5_v",     32'(vld2), 32'd1);
    check("t5_pc",    pc2,      32'hFFFF_FFFC);
    check("t5_ins",   instr2,   32'h0000_0013);
    step();
    check("t1_gap0",  32'(vld), 32'd0);
    step();
    check("t1_pc4",   pc,       32'h4);
    check("t1_v4",    32'(vld), 32'd1);
    check("t1_ins4",  instr,    word(32'h4));
    check("t1_addr8", addr,     32'h8);
    step();
    check("t1_gap4",  32'(vld), 32'd0);
    step();
    check("t1_pc8",   pc,       32'h8);
    check("t1_ins8",  instr,    word(32'h8));

    // decode stalls: second response parks in the skid
    ready = 1'b0;
    restart();
    step(3);
    check("t2_v0",    32'(vld), 32'd1);
    check("t2_pc0",   pc,       32'h0);
    step(2);
    check("t2_hreq",  32'(req), 32'd0);
    check("t2_hpc",   pc,       32'h0);
    step(3);
    check("t2_spc",   pc,       32'h0);
    check("t2_sins",  instr,    word(32'h0));
    check("t2_sreq",  32'(req), 32'd0);
    ready = 1'b1;
    step();
    check("t2_kv",    32'(vld), 32'd1);
    check("t2_kpc",   pc,       32'h4);
    check("t2_kins",  instr,    word(32'h4));
    check("t2_kreq",  32'(req), 32'd1);
    check("t2_kaddr", addr,     32'h8);
    step();
    check("t2_gap",   32'(vld), 32'd0);
    step();
    check("t2_pc8",   pc,       32'h8);
    check("t2_v8",    32'(vld), 32'd1);

    // redirect while waiting on the response for 0x8
    restart();
    step(5);
    check("t3_addr8", addr, 32'h8);
    rv_en = 1'b0;
    step();
    check("t3_wait",  32'(req), 32'd0);
    redir    = 1'b1;
    redir_pc = 32'h0000_0103;
    step();
    redir = 1'b0;
    rv_en = 1'b1;
    check("t3_kv",    32'(vld), 32'd0);
    check("t3_kreq",  32'(req), 32'd0);
    step();
    check("t3_dv",    32'(vld), 32'd0);
    check("t3_dreq",  32'(req), 32'd1);
    check("t3_daddr", addr,     32'h100);
    step(2);
    check("t3_v",     32'(vld), 32'd1);
    check("t3_pc",    pc,       32'h100);
    check("t3_ins",   instr,    word(32'h100));

    // redirect on the grant cycle with 0x8 still presented
    restart();
    step(7);
    check("t4_pc8",   pc,   32'h8);
    check("t4_addrc", addr, 32'hC);
    redir    = 1'b1;
    redir_pc = 32'h0000_0202;
    step();
    redir = 1'b0;
    check("t4_fv",    32'(vld), 32'd0);
    check("t4_freq",  32'(req), 32'd0);
    step();
    check("t4_dv",    32'(vld), 32'd0);
    check("t4_daddr", addr,     32'h200);
    step();
    check("t4_gv",    32'(vld), 32'd0);
    step();
    check("t4_v",     32'(vld), 32'd1);
    check("t4_pc",    pc,       32'h200);
    check("t4_ins",   instr,    word(32'h200));

    // reset mid-wait; stale response lands after release
    restart();
    step(2);
    rv_en = 1'b0;
    check("t6_wait",  32'(req), 32'd0);
    check("t6_addr4", addr,     32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_aaddr", addr,     32'h0);
    check("t6_areq",  32'(req), 32'd0);
    step(2);
    rv_en = 1'b1;
    rst_n = 1'b1;
    step();
    check("t6_sv",    32'(vld), 32'd0);
    check("t6_sreq",  32'(req), 32'd1);
    step();
    check("t6_sv2",   32'(vld), 32'd0);
    step();
    check("t6_v",     32'(vld), 32'd1);
    check("t6_pc",    pc,       32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that sequences the instruction fetch path.
- Owns the PC register and issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid handshake.
- Delivers (pc, instruction) pairs to decode over a valid/ready interface.
- Handles branch/jump redirects by killing the in-flight fetch and flushing buffered instructions; sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_WIDTH, 32, PC / memory address width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- fetch_enable  in  1  1 = allowed to issue new fetch requests.
- redirect_valid  in  1  1 = load redirect_pc and flush; single-cycle pulse.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_WIDTH  word-aligned fetch address.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; at most one per granted request, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts this cycle.
- if_pc  out  ADDR_WIDTH  PC of the presented instruction.
- if_instruction  out  32  presented instruction.

Behaviour:
- Reset (async, while reset=0):
  - state=S_IDLE, pc=RESET_PC, kill=0.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instruction=0.
  - Skid buffer empty.
  - Takes effect mid-transaction; any outstanding response arriving after release is ignored, because S_IDLE discards rvalid.
- States:
  - S_IDLE: imem_req=0. Goes to S_REQ when fetch_enable=1.
  - S_REQ: imem_req=1, imem_addr=pc.
    - On imem_gnt: capture req_pc=pc, pc<=pc+4 (modulo 2^ADDR_WIDTH, wrap 0xFFFF_FFFC -> 0), go to S_WAIT.
    - imem_addr changes while req is high only on redirect.
  - S_WAIT: imem_req=0. On imem_rvalid:
    - kill=1: discard data, clear kill.
    - kill=0, output register empty or consumed this cycle: load output register with (req_pc, imem_rdata).
    - kill=0, output register full and not consumed: load skid buffer, go to S_HOLD.
    - Otherwise, next state is S_REQ if fetch_enable=1, else S_IDLE.
  - S_HOLD: imem_req=0. When if_ready consumes the output register, skid moves to the output register next cycle; then go to S_REQ or S_IDLE per fetch_enable.
- Output handshake:
  - if_valid/if_pc/if_instruction are registered.
  - Transfer occurs when if_valid & if_ready.
  - Outputs stay stable while if_valid=1 and if_ready=0.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2],2'b00}.
  - Output register and skid buffer are invalidated: if_valid=0 next cycle, and the same-cycle if_ready handshake is ignored.
  - S_WAIT, or S_REQ with imem_gnt in the same cycle: kill<=1 and state goes to/stays S_WAIT; the response is dropped.
  - S_REQ without gnt: stay in S_REQ; imem_addr=new pc next cycle.
  - S_HOLD: go to S_REQ or S_IDLE per fetch_enable.
  - Redirect and rvalid in the same cycle in S_WAIT: data dropped, go to S_REQ with the new pc.
- fetch_enable=0:
  - No new request issued; an outstanding request completes normally.
  - A request already in S_REQ is held until gnt (not retracted).
- Latency and throughput:
  - Reset release with fetch_enable=1 gives imem_req=1 in the 1st cycle.
  - With gnt in the same cycle and rvalid one cycle later, if_valid=1 two cycles after gnt.
  - Peak throughput is 1 instruction per 2 cycles (one outstanding request).

Decomposition:
- Shared package/include (fetch_pkg):
  - State encodings S_IDLE/S_REQ/S_WAIT/S_HOLD.
  - PC_STEP=4.
  - NOP encoding 32'h0000_0013 (for downstream bubble insertion).
- One sub-module: fetch_out_buffer, a 2-entry output register plus skid.
  - Ports: push, flush, pop, full, data/pc.
  - Instantiated once; the FSM stays in fetch_sequencer.

Test Plan:
1. Reset release with fetch_enable=1, memory with 1-cycle rvalid, if_ready=1 -> addresses 0x0, 0x4, 0x8 issued; if_pc sequence 0x0, 0x4, 0x8 with matching rdata; one instruction every 2 cycles.
2. if_ready=0 for 6 cycles after first instruction -> second response held in skid, state S_HOLD, imem_req=0; outputs stable at pc 0x0; on if_ready=1, pc 0x4 delivered next, no loss or duplication.
3. Redirect to 0x0000_0103 while in S_WAIT for pc 0x8 -> response for 0x8 dropped; next imem_addr=0x0000_0100; next if_pc=0x100.
4. Redirect in same cycle as imem_gnt for 0xC and the buffered instruction at 0x8 -> if_valid=0 next cycle; both dropped; first delivered if_pc=redirect target.
5. RESET_PC=0xFFFF_FFFC -> addresses 0xFFFF_FFFC then 0x0000_0000 (wrap).
6. Assert reset (0) while in S_WAIT; release; memory fires stale rvalid in the first cycle -> ignored; if_valid stays 0 until fresh fetch of RESET_PC returns.
